// File: rtl/fetch_unit.sv
// Instruction fetch stage: a PC-driven read strobe toward a combinational-read memory.
// The returned word is latched into an instruction register and offered to decode
// over a valid/ready handshake. Redirect reloads the PC and flushes the register.
// Halt parks the stage until the next redirect.
module fetch_unit #(
   parameter int                ADDR_W   = 12,
   parameter int                DATA_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   output logic              mem_read_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic [DATA_W-1:0] mem_data_i,
   output logic [DATA_W-1:0] ir_o,
   output logic [ADDR_W-1:0] ir_pc_o,
   output logic              ir_valid_o,
   input  logic              ir_ready_i,
   input  logic              redirect_i,
   input  logic [ADDR_W-1:0] redirect_pc_i,
   input  logic              halt_i,
   output logic              halted_o
);

   typedef enum logic [1:0] {IDLE, FETCH, HOLD, STOP} state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_inc_d;
   logic [DATA_W-1:0] ir_q;
   logic [ADDR_W-1:0] ir_pc_q;
   logic              ir_valid_q;
   logic              halted_q;

   // Sequential PC; wraps naturally at the top of the address space.
   assign pc_inc_d = pc_q + ADDR_W'(1);

   // The read strobe decodes only the registered state, so it never
   // depends combinationally on handshake or control inputs.
   assign mem_read_o = (state_q == FETCH);
   assign mem_addr_o = pc_q;
   assign ir_o       = ir_q;
   assign ir_pc_o    = ir_pc_q;
   assign ir_valid_o = ir_valid_q;
   assign halted_o   = halted_q;

   // Fetch FSM: redirect beats halt, and halt beats the normal flow.
   // A flush only drops ir_valid. The ir and ir_pc registers keep their last contents.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         ir_q       <= '0;
         ir_pc_q    <= '0;
         ir_valid_q <= 1'b0;
         halted_q   <= 1'b0;
      end else if (redirect_i) begin
         state_q    <= FETCH;
         pc_q       <= redirect_pc_i;
         ir_valid_q <= 1'b0;
         halted_q   <= 1'b0;
      end else if (halt_i && state_q != STOP) begin
         state_q    <= STOP;
         ir_valid_q <= 1'b0;
         halted_q   <= 1'b1;
      end else begin
         case (state_q)
            IDLE: state_q <= FETCH;
            FETCH: begin
               ir_q       <= mem_data_i;
               ir_pc_q    <= pc_q;
               pc_q       <= pc_inc_d;
               ir_valid_q <= 1'b1;
               state_q    <= HOLD;
            end
            HOLD: begin
               if (ir_ready_i) begin
                  ir_valid_q <= 1'b0;
                  state_q    <= FETCH;
               end
            end
            STOP: state_q <= STOP;
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit. It runs a directed vector table, then random traffic
// checked against a phase-level reference model, then an asynchronous reset
// applied in the middle of a fetch.
module tb_fetch_unit;
   localparam int AW = 12;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          mem_read;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data;
   logic [DW-1:0] ir;
   logic [AW-1:0] ir_pc;
   logic          ir_valid;
   logic          ir_ready = 1'b0;
   logic          redirect = 1'b0;
   logic [AW-1:0] redirect_pc = '0;
   logic          halt = 1'b0;
   logic          halted;

   logic [DW-1:0] mem [0:4095];
   assign mem_data = mem[mem_addr];

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC('0)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .mem_read_o(mem_read), .mem_addr_o(mem_addr), .mem_data_i(mem_data),
      .ir_o(ir), .ir_pc_o(ir_pc), .ir_valid_o(ir_valid), .ir_ready_i(ir_ready),
      .redirect_i(redirect), .redirect_pc_i(redirect_pc),
      .halt_i(halt), .halted_o(halted)
   );

   typedef struct {
      logic          rdy;
      logic          rdr;
      logic [AW-1:0] rpc;
      logic          hlt;
      logic          e_mr;
      logic [AW-1:0] e_addr;
      logic          e_iv;
      logic [DW-1:0] e_ir;
      logic [AW-1:0] e_irpc;
      logic          e_hd;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic rdy, input logic rdr, input logic [AW-1:0] rpc,
                      input logic hlt, input logic mr, input logic [AW-1:0] a,
                      input logic iv, input logic [DW-1:0] i, input logic [AW-1:0] ip,
                      input logic hd);
      vec_t v;
      v.rdy = rdy; v.rdr = rdr; v.rpc = rpc; v.hlt = hlt;
      v.e_mr = mr; v.e_addr = a; v.e_iv = iv; v.e_ir = i; v.e_irpc = ip; v.e_hd = hd;
      vq.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      else n_pass++;
   endtask

   task automatic chk_all(input string tag, input logic mr, input logic [AW-1:0] a,
                          input logic iv, input logic [DW-1:0] i,
                          input logic [AW-1:0] ip, input logic hd);
      chk({tag, ".mem_read"}, 32'(mem_read), 32'(mr));
      chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(a));
      chk({tag, ".ir_valid"}, 32'(ir_valid), 32'(iv));
      chk({tag, ".ir"},       32'(ir),       32'(i));
      chk({tag, ".ir_pc"},    32'(ir_pc),    32'(ip));
      chk({tag, ".halted"},   32'(halted),   32'(hd));
   endtask

   // The reset pulse sits between clock edges. After it the next edge moves IDLE to FETCH.
   task automatic pulse_reset();
      @(posedge clk); #1;
      rst_n = 1'b0; ir_ready = 1'b0; redirect = 1'b0; halt = 1'b0;
      #2 rst_n = 1'b1;
   endtask

   // Reference model kept as phase flags rather than a state encoding
   bit      m_idle, m_stop, m_have;
   int      m_pc;
   int      m_ir, m_irpc;

   initial begin
      for (int k = 0; k < 4096; k++) mem[k] = '0;
      mem[0] = 16'h2002; mem[1] = 16'h1003; mem[2] = 16'h0007; mem[3] = 16'h0005;

      // Directed table. Each row gives the inputs for one cycle and the outputs expected before that cycle's edge.
      //   rdy rdr rpc    hlt  mr addr    iv ir        irpc    hd
      add(1, 0, 12'h000, 0,   0, 12'h000, 0, 16'h0000, 12'h000, 0); // IDLE
      add(1, 0, 12'h000, 0,   1, 12'h000, 0, 16'h0000, 12'h000, 0); // FETCH 000
      for (int k = 0; k < 5; k++)
         add(0, 0, 12'h000, 0, 0, 12'h001, 1, 16'h2002, 12'h000, 0); // HOLD, stalled
      add(1, 0, 12'h000, 0,   0, 12'h001, 1, 16'h2002, 12'h000, 0); // HOLD accept
      add(1, 1, 12'h003, 0,   1, 12'h001, 0, 16'h2002, 12'h000, 0); // FETCH 001 + redirect
      add(1, 0, 12'h000, 0,   1, 12'h003, 0, 16'h2002, 12'h000, 0); // FETCH 003
      add(1, 0, 12'h000, 0,   0, 12'h004, 1, 16'h0005, 12'h003, 0); // HOLD 0005
      add(1, 1, 12'hFFF, 0,   1, 12'h004, 0, 16'h0005, 12'h003, 0); // FETCH 004 + redirect FFF
      add(1, 0, 12'h000, 0,   1, 12'hFFF, 0, 16'h0005, 12'h003, 0); // FETCH FFF
      add(0, 0, 12'h000, 1,   0, 12'h000, 1, 16'h0000, 12'hFFF, 0); // HOLD (wrapped) + halt
      for (int k = 0; k < 10; k++)
         add(k[0], 0, 12'h000, k[1], 0, 12'h000, 0, 16'h0000, 12'hFFF, 1); // STOP
      add(1, 1, 12'h002, 1,   0, 12'h000, 0, 16'h0000, 12'hFFF, 1); // STOP, redirect+halt
      add(0, 0, 12'h000, 0,   1, 12'h002, 0, 16'h0000, 12'hFFF, 0); // FETCH 002
      add(1, 0, 12'h000, 0,   0, 12'h003, 1, 16'h0007, 12'h002, 0); // HOLD 0007
      add(0, 1, 12'h010, 1,   1, 12'h003, 0, 16'h0007, 12'h002, 0); // FETCH 003, redirect+halt
      add(0, 0, 12'h000, 0,   1, 12'h010, 0, 16'h0007, 12'h002, 0); // redirect won

      #3 rst_n = 1'b1;
      chk_all("reset", 0, 12'h000, 0, 16'h0000, 12'h000, 0);
      pulse_reset();
      foreach (vq[k]) begin
         ir_ready = vq[k].rdy; redirect = vq[k].rdr;
         redirect_pc = vq[k].rpc; halt = vq[k].hlt;
         @(negedge clk);
         chk_all($sformatf("vec%0d", k), vq[k].e_mr, vq[k].e_addr, vq[k].e_iv,
                 vq[k].e_ir, vq[k].e_irpc, vq[k].e_hd);
         @(posedge clk); #1;
      end

      // Random traffic against the model
      for (int k = 0; k < 4096; k++) mem[k] = DW'($urandom);
      pulse_reset();
      m_idle = 1; m_stop = 0; m_have = 0; m_pc = 0; m_ir = 0; m_irpc = 0;
      for (int c = 0; c < 1500; c++) begin
         ir_ready = 1'($urandom_range(0, 1));
         redirect = ($urandom_range(0, 15) == 0);
         halt     = ($urandom_range(0, 15) == 0);
         redirect_pc = AW'($urandom);
         @(negedge clk);
         chk_all("rand", !m_idle && !m_stop && !m_have, AW'(m_pc), m_have,
                 DW'(m_ir), AW'(m_irpc), m_stop);
         if (redirect) begin
            m_pc = redirect_pc; m_have = 0; m_stop = 0; m_idle = 0;
         end else if (halt && !m_stop) begin
            m_have = 0; m_stop = 1; m_idle = 0;
         end else if (m_idle) begin
            m_idle = 0;
         end else if (!m_stop) begin
            if (!m_have) begin
               m_ir = mem[m_pc]; m_irpc = m_pc; m_pc = (m_pc + 1) % 4096; m_have = 1;
            end else if (ir_ready) begin
               m_have = 0;
            end
         end
         @(posedge clk); #1;
      end

      // Asynchronous reset dropped in the middle of a fetch
      ir_ready = 1'b1; halt = 1'b0; redirect = 1'b1; redirect_pc = 12'h123;
      @(posedge clk); #1;
      redirect = 1'b0;
      @(posedge clk); #1;   // HOLD with a valid word
      @(posedge clk); #1;   // FETCH
      chk("mid.pre_mem_read", 32'(mem_read), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk_all("async_rst", 0, 12'h000, 0, 16'h0000, 12'h000, 0);
      @(negedge clk);
      chk("async_rst.hold_low", 32'(mem_read), 32'd0);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst.idle_read", 32'(mem_read), 32'd1);
      chk("post_rst.addr", 32'(mem_addr), 32'h000);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
